// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM device model and its storage.
package sram_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int SRAM_LANES  = 2;

    typedef enum logic [2:0] {
        IDLE,
        READ_ACCESS,
        READ_DRIVE,
        WRITE_PULSE,
        WRITE_ABORT
    } sram_state_t;

endpackage

// File: rtl/sram_byte_array.sv
// Word storage split into two byte lanes, with one synchronous write port
// and one asynchronous read port. Contents are never reset.
module sram_byte_array
    import sram_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic                   clk_i,
    input  logic [SRAM_LANES-1:0]  we_i,
    input  logic [AW-1:0]          waddr_i,
    input  logic [SRAM_DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]          raddr_i,
    output logic [SRAM_DATA_W-1:0] rdata_o
);

    logic [7:0]               lowLane_q  [0:(1<<AW)-1];
    logic [SRAM_DATA_W-9:0]   highLane_q [0:(1<<AW)-1];

    // Each lane is written independently so partial-word writes leave the other byte intact.
    always_ff @(posedge clk_i) begin
        if (we_i[0]) begin
            lowLane_q[waddr_i] <= wdata_i[7:0];
        end
        if (we_i[1]) begin
            highLane_q[waddr_i] <= wdata_i[SRAM_DATA_W-1:8];
        end
    end

    assign rdata_o = {highLane_q[raddr_i], lowLane_q[raddr_i]};

endmodule

// File: rtl/sram_device_model.sv
// Cycle-counted responder for a 256K x 16 asynchronous SRAM pin interface.
// Reads are presented after a fixed latency; writes commit on the rising
// edge of we_n only if the low pulse was long enough and the address held.
module sram_device_model
    import sram_pkg::*;
#(
    parameter int ADDR_W       = SRAM_ADDR_W,
    parameter int DATA_W       = SRAM_DATA_W,
    parameter int MEM_AW       = 10,
    parameter int READ_LATENCY = 10,
    parameter int WR_PULSE_MIN = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address_in,
    inout  logic [DATA_W-1:0] dq,
    input  logic              ce_n,
    input  logic              oe_n,
    input  logic              we_n,
    input  logic              lb_n,
    input  logic              ub_n,
    output logic              read_active,
    output logic              write_commit,
    output logic [15:0]       commit_count,
    output logic              timing_error
);

    localparam logic [7:0] LAT_LOAD  = 8'(READ_LATENCY);
    localparam logic [7:0] PULSE_MIN = 8'(WR_PULSE_MIN);

    sram_state_t             state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [SRAM_LANES-1:0]   wlanes_q, wlanes_d;
    logic                    commit_q, commit_d;
    logic [15:0]             count_q, count_d;
    logic                    terr_q, terr_d;

    logic                    rd, wr, addrChanged, startWrite;
    logic                    driveLo, driveHi;
    logic [SRAM_LANES-1:0]   memWe;
    logic [DATA_W-1:0]       rdata;

    assign rd          = ~ce_n & ~oe_n & we_n;
    assign wr          = ~ce_n & ~we_n;
    assign addrChanged = (address_in != addr_q);

    // Register all protocol state; reset aborts any write in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            wdata_q  <= '0;
            wlanes_q <= '0;
            commit_q <= 1'b0;
            count_q  <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            wdata_q  <= wdata_d;
            wlanes_q <= wlanes_d;
            commit_q <= commit_d;
            count_q  <= count_d;
            terr_q   <= terr_d;
        end
    end

    // Next-state logic; a write cycle always pre-empts a read in progress.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        wdata_d    = wdata_q;
        wlanes_d   = wlanes_q;
        commit_d   = 1'b0;
        count_d    = count_q;
        terr_d     = terr_q;
        memWe      = '0;
        startWrite = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr) begin
                    startWrite = 1'b1;
                end else if (rd) begin
                    state_d = READ_ACCESS;
                    addr_d  = address_in;
                    cnt_d   = LAT_LOAD;
                end
            end
            READ_ACCESS: begin
                if (wr) begin
                    startWrite = 1'b1;
                end else if (!rd) begin
                    state_d = IDLE;
                end else if (addrChanged) begin
                    addr_d = address_in;
                    cnt_d  = LAT_LOAD;
                end else if (cnt_q <= 8'd1) begin
                    state_d = READ_DRIVE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            READ_DRIVE: begin
                if (wr) begin
                    startWrite = 1'b1;
                end else if (!rd) begin
                    state_d = IDLE;
                end else if (addrChanged) begin
                    state_d = READ_ACCESS;
                    addr_d  = address_in;
                    cnt_d   = LAT_LOAD;
                end
            end
            WRITE_PULSE: begin
                if (wr) begin
                    if (addrChanged) begin
                        terr_d  = 1'b1;
                        state_d = WRITE_ABORT;
                    end else begin
                        if (cnt_q != 8'hff) begin
                            cnt_d = cnt_q + 8'd1;
                        end
                        wdata_d  = dq;
                        wlanes_d = {~ub_n, ~lb_n};
                    end
                end else begin
                    state_d = IDLE;
                    if (cnt_q >= PULSE_MIN) begin
                        memWe    = wlanes_q;
                        commit_d = 1'b1;
                        count_d  = count_q + 16'd1;
                    end else begin
                        terr_d = 1'b1;
                    end
                end
            end
            WRITE_ABORT: begin
                if (!wr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (startWrite) begin
            state_d  = WRITE_PULSE;
            addr_d   = address_in;
            cnt_d    = 8'd1;
            wdata_d  = dq;
            wlanes_d = {~ub_n, ~lb_n};
        end
    end

    sram_byte_array #(
        .AW(MEM_AW)
    ) u_array (
        .clk_i   (clk),
        .we_i    (memWe),
        .waddr_i (addr_q[MEM_AW-1:0]),
        .wdata_i (wdata_q),
        .raddr_i (addr_q[MEM_AW-1:0]),
        .rdata_o (rdata)
    );

    // Lanes follow the live control pins so the bus is released in the same cycle.
    assign driveLo = (state_q == READ_DRIVE) & rd & ~lb_n;
    assign driveHi = (state_q == READ_DRIVE) & rd & ~ub_n;

    assign dq[7:0]        = driveLo ? rdata[7:0] : 8'hzz;
    assign dq[DATA_W-1:8] = driveHi ? rdata[DATA_W-1:8] : {(DATA_W-8){1'bz}};

    assign read_active  = (state_q == READ_ACCESS) | (state_q == READ_DRIVE);
    assign write_commit = commit_q;
    assign commit_count = count_q;
    assign timing_error = terr_q;

endmodule

// File: doc/sram_device_model.md
Name: sram_device_model

Overview:
- Clocked, synthesizable model of the 256K x 16 asynchronous SRAM on the far side of the SRAMController pin interface (address, dq, ce_n, oe_n, we_n, lb_n, ub_n).
- Responds to controller-generated read and write cycles with cycle-counted access latency, write-pulse checking and per-byte lane control.
- Used as the memory responder in controller and system-level simulation, and on FPGA builds without the external part; exposes status outputs for scoreboarding.

Parameters:
- ADDR_W, 18, external address width.
- DATA_W, 16, data bus width (two byte lanes).
- MEM_AW, 10, implemented storage depth is 2**MEM_AW words; address bits above MEM_AW-1 are ignored (aliasing).
- READ_LATENCY, 10, cycles from sampled read request to dq driven (1..255).
- WR_PULSE_MIN, 5, minimum number of consecutive sampled-low we_n cycles for a valid write (1..255).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- address_in  in  ADDR_W  address from controller.
- dq  inout  DATA_W  bidirectional data bus.
- ce_n, oe_n, we_n, lb_n, ub_n  in  1 each  active-low chip, output, write and lower/upper byte enables.
- read_active  out  1  high while in READ_ACCESS or READ_DRIVE.
- write_commit  out  1  one-cycle pulse when a write is committed to storage.
- commit_count  out  16  number of committed writes; wraps at 16'hffff -> 0.
- timing_error  out  1  sticky flag; cleared only by rst.

Behaviour:
- Reset: FSM=IDLE, counters=0, read_active=0, write_commit=0, commit_count=0, timing_error=0, dq released (all Z). Storage is not cleared; reset mid-cycle aborts any pending write with no commit.
- Definitions: RD = ~ce_n & ~oe_n & we_n. WR = ~ce_n & ~we_n. WR has priority over RD, so oe_n is don't-care during writes.
- FSM states: IDLE, READ_ACCESS, READ_DRIVE, WRITE_PULSE, WRITE_ABORT. Controls are sampled at the clock edge.
- IDLE:
  - WR -> WRITE_PULSE; latch address, set pulse count to 1.
  - Else RD -> READ_ACCESS; latch address, load latency counter.
- READ_ACCESS:
  - WR -> WRITE_PULSE.
  - ~RD -> IDLE.
  - Address differs from latched -> reload counter, latch new address.
  - Otherwise decrement. If RD is first sampled at edge k with a stable address, the FSM is in READ_DRIVE after edge k+READ_LATENCY.
- READ_DRIVE:
  - Lower lane drives mem[addr][7:0] iff state==READ_DRIVE & RD & ~lb_n (combinational gating; no contention cycle after oe_n/ce_n rise or we_n fall). Upper lane likewise with ub_n and [15:8]. Undriven lanes are Z.
  - Address change -> READ_ACCESS with reload (bus released).
  - WR -> WRITE_PULSE.
  - ~RD -> IDLE.
- WRITE_PULSE:
  - dq is never driven.
  - Each edge with WR and unchanged address: count saturates at 255; sample dq, ~lb_n and ~ub_n (last sample wins).
  - First edge with ~WR:
    - If count >= WR_PULSE_MIN: write the enabled bytes to mem[addr[MEM_AW-1:0]], pulse write_commit in the following cycle, increment commit_count, -> IDLE.
    - Else: set timing_error, no commit, -> IDLE.
    - Both byte enables high: no storage change, but the write still counts as a commit.
  - Address change while WR: set timing_error, -> WRITE_ABORT.
- WRITE_ABORT: no commit; -> IDLE on first edge with ~WR.
- Read-after-write to the same address returns the new data (commit precedes the next read sample).

Decomposition:
- Package sram_pkg:
  - sram_state_t enum (the five states).
  - Constants SRAM_ADDR_W=18, SRAM_DATA_W=16, SRAM_LANES=2.
- Sub-module sram_byte_array: 2**MEM_AW x 16 storage with per-lane write enables, one synchronous write port and one asynchronous read port.

Test Plan:
- Reset, then ce_n=oe_n=we_n=lb_n=ub_n=1 -> dq all Z; read_active=0, write_commit=0, commit_count=0, timing_error=0.
- Write 16'h2004 to 18'h3ffff with we_n low for 6 cycles, both lanes enabled -> write_commit pulses once, commit_count=1, timing_error=0, dq never driven by the model.
- Read 18'h3ffff (ce_n=oe_n=0, we_n=1) -> dq Z for 10 edges, then 16'h2004 after edge k+10. Raise oe_n -> dq Z the same cycle.
- Aliasing and byte lanes: write 16'hab04 to 18'h003ff, then write 16'hffff with ub_n=1 to 18'h3ffff, then read 18'h003ff -> 16'habff. Read with lb_n=1 -> dq[7:0] Z, dq[15:8]=8'hab.
- Short pulse: we_n low for 3 cycles with data 16'h1234 -> no write_commit, timing_error=1, storage unchanged. A subsequent valid write -> commit proceeds; timing_error stays 1.
- Address change mid-read at cycle 5 -> dq Z until 10 edges after the change. Address change mid-write -> timing_error=1, no commit. rst asserted mid-write -> no commit, all outputs return to reset values.
